keypad_scanner: RTL and testbench

Scan controller for the 4x4 matrix keypad. It drives the columns one at a time and samples the rows after a settle window. It filters at scan level, requiring the same key for a set number of consecutive full scans, and reports one event per press. It sits between the keypad pins and the key-consuming logic and replaces per-line debouncing of the row inputs.

---
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Scan controller for a 4x4 active-low matrix keypad: drives one column at a time,
// samples the rows after a settle window and confirms keys over identical full scans.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int STABLE_SCANS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int MW = $clog2(STABLE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_TARGET = MW'(STABLE_SCANS);

  typedef enum logic {RELEASED, PRESSED} state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic          active;
  logic [SW-1:0] settle_cnt;
  logic [1:0]    col_idx;
  logic [15:0]   scan_map;
  logic          map_ready;
  logic [4:0]    map_count;
  logic [3:0]    map_code;
  logic          eval_valid;
  logic          eval_none;
  logic          eval_single;
  logic [3:0]    eval_code;
  state_t        state;
  logic [3:0]    candidate;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_base;
  logic [MW-1:0] next_match;

  always_ff @(posedge clk) begin
    row_meta <= row_in;
    row_sync <= row_meta;
  end

  // Column sequencer: each column is driven for a full settle window, sampled on its last cycle.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      active     <= 1'b0;
      col_out    <= 4'b1111;
      settle_cnt <= '0;
      col_idx    <= '0;
      scan_map   <= '0;
      map_ready  <= 1'b0;
    end else if (!active) begin
      active     <= 1'b1;
      col_out    <= 4'b1110;
      settle_cnt <= '0;
      col_idx    <= '0;
      map_ready  <= 1'b0;
    end else if (settle_cnt == SETTLE_LAST) begin
      for (int r = 0; r < 4; r++) begin
        scan_map[{2'(r), col_idx}] <= ~row_sync[r];
      end
      map_ready  <= (col_idx == 2'd3);
      settle_cnt <= '0;
      col_idx    <= col_idx + 2'd1;
      col_out    <= ~(4'b0001 << (col_idx + 2'd1));
    end else begin
      settle_cnt <= settle_cnt + SW'(1);
      map_ready  <= 1'b0;
    end
  end

  always_comb begin
    map_count = '0;
    map_code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_map[i]) begin
        map_count = map_count + 5'd1;
        map_code  = 4'(i);
      end
    end
  end

  // Classify the completed scan one cycle after the column-3 sample.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      eval_valid  <= 1'b0;
      eval_none   <= 1'b0;
      eval_single <= 1'b0;
      eval_code   <= '0;
      multi_key   <= 1'b0;
    end else begin
      eval_valid <= map_ready;
      if (map_ready) begin
        eval_none   <= (map_count == 5'd0);
        eval_single <= (map_count == 5'd1);
        eval_code   <= map_code;
        multi_key   <= (map_count >= 5'd2);
      end
    end
  end

  // A different key while released restarts the run; the counter saturates at its target.
  always_comb begin
    match_base = match_cnt;
    if (state == RELEASED && eval_code != candidate) begin
      match_base = '0;
    end
    next_match = (match_base == MATCH_TARGET) ? match_base : match_base + MW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code <= '0;
    end
    if (rst || !enable) begin
      state     <= RELEASED;
      candidate <= '0;
      match_cnt <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (eval_valid) begin
        case (state)
          RELEASED: begin
            if (eval_single) begin
              candidate <= eval_code;
              if (next_match == MATCH_TARGET) begin
                state     <= PRESSED;
                key_code  <= eval_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                match_cnt <= '0;
              end else begin
                match_cnt <= next_match;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          PRESSED: begin
            if (eval_none) begin
              if (next_match == MATCH_TARGET) begin
                state     <= RELEASED;
                key_held  <= 1'b0;
                match_cnt <= '0;
                candidate <= '0;
              end else begin
                match_cnt <= next_match;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad pin model, a scan-level reference model checked every
// cycle, a table of scripted segments and a randomized phase.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int STABLE = 2;
  localparam int SCAN   = 4 * SETTLE;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;
  logic [15:0] pressed;

  keypad_scanner #(.SETTLE_CYCLES(SETTLE), .STABLE_SCANS(STABLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && col_out[c] == 1'b0) row_in[r] = 1'b0;
      end
    end
  end

  int checks;
  int errors;
  int pulse_cnt;

  // Reference model: scan results are whole-keypad snapshots; a press is the last STABLE
  // results all being the same single key, a release the last STABLE results all empty.
  bit          m_active;
  bit          m_pressed_state;
  int          m_s;
  logic [15:0] hist [SCAN];
  int          multi_in;
  int          fsm_in;
  int          pend_res;
  int          recent[$];
  logic [3:0]  exp_col;
  int          exp_code;
  int          exp_valid;
  int          exp_held;
  int          exp_multi;

  function automatic int classify();
    logic [15:0] snap;
    int n;
    int code;
    snap = '0;
    n = 0;
    code = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (hist[c*SETTLE + SETTLE - 3][r*4+c]) snap[r*4+c] = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        n++;
        code = i;
      end
    end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return code;
  endfunction

  function automatic bit tail_all(input int v);
    if (recent.size() < STABLE) return 1'b0;
    for (int i = recent.size() - STABLE; i < recent.size(); i++) begin
      if (recent[i] != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic apply_filter(input int res);
    recent.push_back(res);
    if (!m_pressed_state) begin
      if (res >= 0 && tail_all(res)) begin
        exp_code = res;
        exp_valid = 1;
        exp_held = 1;
        m_pressed_state = 1'b1;
        recent.delete();
      end
    end else if (res == -1 && tail_all(-1)) begin
      exp_held = 0;
      m_pressed_state = 1'b0;
      recent.delete();
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [15:0] p);
    exp_valid = 0;
    if (r || !e) begin
      m_active = 1'b0;
      exp_col = 4'hF;
      exp_held = 0;
      exp_multi = 0;
      m_pressed_state = 1'b0;
      recent.delete();
      multi_in = 0;
      fsm_in = 0;
      if (r) exp_code = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_s = 0;
      exp_col = 4'b1110;
    end else begin
      hist[m_s % SCAN] = p;
      if (multi_in > 0) begin
        multi_in--;
        if (multi_in == 0) exp_multi = (pend_res == -2) ? 1 : 0;
      end
      if (fsm_in > 0) begin
        fsm_in--;
        if (fsm_in == 0) apply_filter(pend_res);
      end
      if (m_s % SCAN == SCAN - 1) begin
        pend_res = classify();
        multi_in = 1;
        fsm_in = 2;
      end
      m_s++;
      exp_col = ~(4'b0001 << ((m_s / SETTLE) % 4));
    end
  endtask

  task automatic check_value(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    check_value("col_out", int'(col_out), int'(exp_col));
    check_value("key_code", int'(key_code), exp_code);
    check_value("key_valid", int'(key_valid), exp_valid);
    check_value("key_held", int'(key_held), exp_held);
    check_value("multi_key", int'(multi_key), exp_multi);
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] p);
    rst = r;
    enable = e;
    pressed = p;
    @(posedge clk);
    model_edge(r, e, p);
    @(negedge clk);
    if (key_valid === 1'b1) pulse_cnt++;
    checkOutput();
  endtask

  typedef struct {
    logic        rst_v;
    logic        en_v;
    logic [15:0] keys;
    int          cycles;
    int          exp_code;
    int          exp_held;
    int          exp_multi;
    int          exp_pulses;
    logic [3:0]  exp_col;
  } seg_t;

  seg_t segs[$];

  task automatic add_seg(input logic r, input logic e, input logic [15:0] k, input int n,
                         input int code, input int held, input int multi, input int pulses,
                         input logic [3:0] col);
    seg_t s;
    s.rst_v = r;
    s.en_v = e;
    s.keys = k;
    s.cycles = n;
    s.exp_code = code;
    s.exp_held = held;
    s.exp_multi = multi;
    s.exp_pulses = pulses;
    s.exp_col = col;
    segs.push_back(s);
  endtask

  int          kind;
  int          len;
  logic [15:0] pat;

  initial begin
    checks = 0;
    errors = 0;
    pulse_cnt = 0;
    rst = 1'b1;
    enable = 1'b0;
    pressed = '0;
    m_active = 1'b0;
    m_pressed_state = 1'b0;
    m_s = 0;
    multi_in = 0;
    fsm_in = 0;
    pend_res = -1;
    exp_col = 4'hF;
    exp_code = 0;
    exp_valid = 0;
    exp_held = 0;
    exp_multi = 0;
    for (int i = 0; i < SCAN; i++) hist[i] = '0;

    add_seg(1, 0, 16'h0000,   3, 0, 0, 0, 0, 4'hF);
    add_seg(0, 1, 16'h0000,  64, 0, 0, 0, 0, 4'h7);
    add_seg(0, 1, 16'h0200, 192, 9, 1, 0, 1, 4'h7);
    add_seg(0, 1, 16'h0000,  16, 9, 1, 0, 0, 4'h7);
    add_seg(0, 1, 16'h0200,  32, 9, 1, 0, 0, 4'h7);
    add_seg(0, 1, 16'h0000,  48, 9, 0, 0, 0, 4'h7);
    add_seg(0, 1, 16'h0001,  48, 0, 1, 0, 1, 4'h7);
    add_seg(0, 1, 16'h0000,  48, 0, 0, 0, 0, 4'h7);
    for (int i = 0; i < 3; i++) begin
      add_seg(0, 1, 16'h8000, 16, 0, 0, 0, 0, 4'h7);
      add_seg(0, 1, 16'h0000, 16, 0, 0, 0, 0, 4'h7);
    end
    add_seg(0, 1, 16'h8000,  48, 15, 1, 0, 1, 4'h7);
    add_seg(0, 1, 16'h0000,  48, 15, 0, 0, 0, 4'h7);
    add_seg(0, 1, 16'h0041,  48, 15, 0, 1, 0, 4'h7);
    add_seg(0, 1, 16'h0040,  48, 6, 1, 0, 1, 4'h7);
    add_seg(0, 1, 16'h0041,  48, 6, 1, 1, 0, 4'h7);
    add_seg(0, 1, 16'h0000,  48, 6, 0, 0, 0, 4'h7);
    add_seg(0, 1, 16'h0200,  48, 9, 1, 0, 1, 4'h7);
    add_seg(0, 1, 16'h0200,  10, 9, 1, 0, 0, 4'hB);
    add_seg(0, 0, 16'h0200,   1, 9, 0, 0, 0, 4'hF);
    add_seg(0, 1, 16'h0000,  64, 9, 0, 0, 0, 4'h7);
    add_seg(0, 1, 16'h0020,  27, 9, 0, 0, 0, 4'hB);
    add_seg(1, 1, 16'h0020,   1, 0, 0, 0, 0, 4'hF);
    add_seg(0, 1, 16'h0000,  64, 0, 0, 0, 0, 4'h7);

    foreach (segs[i]) begin
      pulse_cnt = 0;
      for (int k = 0; k < segs[i].cycles; k++) begin
        applyStimulus(segs[i].rst_v, segs[i].en_v, segs[i].keys);
      end
      check_value($sformatf("seg%0d key_code", i), int'(key_code), segs[i].exp_code);
      check_value($sformatf("seg%0d key_held", i), int'(key_held), segs[i].exp_held);
      check_value($sformatf("seg%0d multi_key", i), int'(multi_key), segs[i].exp_multi);
      check_value($sformatf("seg%0d pulses", i), pulse_cnt, segs[i].exp_pulses);
      check_value($sformatf("seg%0d col_out", i), int'(col_out), int'(segs[i].exp_col));
    end

    // Exact press latency: key (2,2) confirmed two cycles after the second scan's last sample.
    for (int k = 0; k < 34; k++) applyStimulus(1'b0, 1'b1, 16'h0400);
    check_value("latency pre key_valid", int'(key_valid), 0);
    applyStimulus(1'b0, 1'b1, 16'h0400);
    check_value("latency key_valid", int'(key_valid), 1);
    check_value("latency key_code", int'(key_code), 10);
    applyStimulus(1'b0, 1'b1, 16'h0400);
    check_value("latency post key_valid", int'(key_valid), 0);
    for (int k = 0; k < 3 * SCAN; k++) applyStimulus(1'b0, 1'b1, 16'h0000);
    check_value("latency release key_held", int'(key_held), 0);

    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(0, 19);
      len = $urandom_range(6, 40);
      if (kind < 7) pat = '0;
      else if (kind < 15) pat = 16'h0001 << $urandom_range(0, 15);
      else pat = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      if (kind == 18) begin
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) applyStimulus(1'b0, 1'b0, pat);
      end else if (kind == 19) begin
        applyStimulus(1'b1, 1'b1, pat);
      end else begin
        for (int k = 0; k < len; k++) applyStimulus(1'b0, 1'b1, pat);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
